// File: rtl/rv_div_ctrl.sv
// ============================================================================
// rv_div_ctrl
// ----------------------------------------------------------------------------
// Sequencer between the EX stage and a signed 64-bit radix-4 SRT divider core.
// It handles the RV64M DIV/DIVU/REM/REMU operations and their *W variants.
// Per request it:
//   - decodes the operation and prepares the operands (sign/zero extension
//     for word ops),
//   - answers divide-by-zero, signed overflow and unsigned divisors with the
//     MSB set directly, without starting the core,
//   - otherwise hands the operands to the core with a one-cycle vld&ready
//     handshake,
//   - runs one restoring step afterwards for unsigned dividends with the MSB
//     set,
//   - returns a single result on a valid/ready response port.
//
// Ports
//   clk, rstn            clock, asynchronous active-low reset
//   req_vld_i/req_rdy_o  request handshake
//   funct3_i, word_i     operation (100 DIV, 101 DIVU, 110 REM, 111 REMU), *W
//   op1_i, op2_i, tag_i  dividend, divisor, destination tag
//   flush_i              pipeline kill
//   resp_vld_o/resp_rdy_i, resp_data_o, resp_tag_o
//                        result handshake, result, tag
//   busy_o               controller is not idle
//   div_vld_o, div_op1_o, div_op2_o
//                        request to the divider core
//   div_quo_i, div_rem_i, div_ready_i
//                        divider core results and ready
// ============================================================================
module rv_div_ctrl #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_vld_i,
    output logic             req_rdy_o,
    input  logic [2:0]       funct3_i,
    input  logic             word_i,
    input  logic [XLEN-1:0]  op1_i,
    input  logic [XLEN-1:0]  op2_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             resp_vld_o,
    input  logic             resp_rdy_i,
    output logic [XLEN-1:0]  resp_data_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic             busy_o,
    output logic             div_vld_o,
    output logic [XLEN-1:0]  div_op1_o,
    output logic [XLEN-1:0]  div_op2_o,
    input  logic [XLEN-1:0]  div_quo_i,
    input  logic [XLEN-1:0]  div_rem_i,
    input  logic             div_ready_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_WAIT,
        S_FIX,
        S_RESP
    } state_e;

    // Most negative value of the prepared dividend: 64-bit, or a word value
    // after sign extension.
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, {31{1'b0}}};

    // Picks the quotient or the remainder. Word ops sign-extend bit 31 of
    // the picked value.
    function automatic logic [XLEN-1:0] select_result(
        input logic            rem_sel,
        input logic            word,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem
    );
        logic [XLEN-1:0] v;
        v = rem_sel ? rem : quo;
        if (word) begin
            v = {{(XLEN-32){v[31]}}, v[31:0]};
        end
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic                rdy_en_q;
    logic                rem_sel_q, rem_sel_d;
    logic                word_q, word_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                fix_q, fix_d;
    logic                kill_q, kill_d;
    logic                a0_q, a0_d;
    logic [XLEN-2:0]     quo_q, quo_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic [XLEN-1:0]     div_op1_q, div_op1_d;
    logic [XLEN-1:0]     div_op2_q, div_op2_d;

    // ------------------------------------------------------------------
    // Operand preparation and fast-path detection on the incoming request
    // ------------------------------------------------------------------
    logic                is_uns;
    logic [XLEN-1:0]     a_prep;
    logic [XLEN-1:0]     b_prep;
    logic                b_zero;
    logic                sgn_ovf;
    logic                uns_big;
    logic                need_fix;
    logic                fast;
    logic [XLEN-1:0]     fast_quo;
    logic [XLEN-1:0]     fast_rem;
    logic                accept;
    logic                unused_funct3;

    // funct3[2] is always set for the divide group, so the decode ignores it.
    assign unused_funct3 = funct3_i[2];
    assign is_uns        = funct3_i[0];

    // Word ops use only the low 32 bits of each operand. They are extended
    // to 64 bits so that the signed 64-bit core gives the right answer.
    always_comb begin
        a_prep = op1_i;
        b_prep = op2_i;
        if (word_i) begin
            if (is_uns) begin
                a_prep = {{(XLEN-32){1'b0}}, op1_i[31:0]};
                b_prep = {{(XLEN-32){1'b0}}, op2_i[31:0]};
            end else begin
                a_prep = {{(XLEN-32){op1_i[31]}}, op1_i[31:0]};
                b_prep = {{(XLEN-32){op2_i[31]}}, op2_i[31:0]};
            end
        end
    end

    // The signed core cannot handle unsigned 64-bit values with the MSB set:
    //   - A large divisor gives a quotient of 0 or 1, decided here.
    //   - A large dividend is halved before it goes to the core, and the
    //     lost bit is restored in the FIX state.
    assign b_zero   = (b_prep == '0);
    assign sgn_ovf  = !is_uns && (a_prep == (word_i ? MIN_W : MIN_D)) && (b_prep == '1);
    assign uns_big  = is_uns && !word_i && b_prep[XLEN-1];
    assign need_fix = is_uns && !word_i && a_prep[XLEN-1] && !b_prep[XLEN-1];
    assign fast     = b_zero || sgn_ovf || uns_big;

    always_comb begin
        fast_quo = '0;
        fast_rem = a_prep;
        if (b_zero) begin
            fast_quo = '1;
            fast_rem = a_prep;
        end else if (sgn_ovf) begin
            fast_quo = a_prep;
            fast_rem = '0;
        end else begin
            fast_quo[0] = (a_prep >= b_prep);
            fast_rem    = fast_quo[0] ? (a_prep - b_prep) : a_prep;
        end
    end

    // ------------------------------------------------------------------
    // Final restoring step for halved unsigned dividends. The shifted
    // remainder needs 65 bits for the comparison. Its difference with B
    // always fits in 64 bits.
    // ------------------------------------------------------------------
    logic [XLEN:0]       fix_r;
    logic                fix_ge;
    logic [XLEN-1:0]     fix_quo;
    logic [XLEN-1:0]     fix_rem;

    assign fix_r   = {rem_q, a0_q};
    assign fix_ge  = (fix_r >= {1'b0, div_op2_q});
    assign fix_quo = {quo_q, fix_ge};
    assign fix_rem = fix_ge ? (fix_r[XLEN-1:0] - div_op2_q) : fix_r[XLEN-1:0];

    // ------------------------------------------------------------------
    // Handshake outputs
    // rdy_en_q holds req_rdy_o low during reset and for the first edge
    // after reset.
    // ------------------------------------------------------------------
    assign req_rdy_o   = (state_q == S_IDLE) && rdy_en_q && !flush_i;
    assign accept      = req_vld_i && req_rdy_o;
    assign div_vld_o   = (state_q == S_ISSUE) && !flush_i;
    assign resp_vld_o  = (state_q == S_RESP);
    assign busy_o      = (state_q != S_IDLE);
    assign resp_data_o = res_q;
    assign resp_tag_o  = tag_q;
    assign div_op1_o   = div_op1_q;
    assign div_op2_o   = div_op2_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // A kill flag records a flush that arrives while the core is working.
    // The controller waits for the core to finish, then drops the result.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rem_sel_d = rem_sel_q;
        word_d    = word_q;
        tag_d     = tag_q;
        fix_d     = fix_q;
        kill_d    = kill_q;
        a0_d      = a0_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        res_d     = res_q;
        div_op1_d = div_op1_q;
        div_op2_d = div_op2_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_sel_d = funct3_i[1];
                    word_d    = word_i;
                    tag_d     = tag_i;
                    kill_d    = 1'b0;
                    fix_d     = 1'b0;
                    if (fast) begin
                        res_d   = select_result(funct3_i[1], word_i, fast_quo, fast_rem);
                        state_d = S_RESP;
                    end else begin
                        div_op1_d = need_fix ? (a_prep >> 1) : a_prep;
                        div_op2_d = b_prep;
                        fix_d     = need_fix;
                        a0_d      = a_prep[0];
                        state_d   = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (div_ready_i) begin
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                if (flush_i) begin
                    kill_d = 1'b1;
                end
                if (!div_ready_i) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (div_ready_i) begin
                    if (kill_q || flush_i) begin
                        state_d = S_IDLE;
                    end else if (fix_q) begin
                        quo_d   = div_quo_i[XLEN-2:0];
                        rem_d   = div_rem_i;
                        state_d = S_FIX;
                    end else begin
                        res_d   = select_result(rem_sel_q, word_q, div_quo_i, div_rem_i);
                        state_d = S_RESP;
                    end
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end

            S_FIX: begin
                if (kill_q || flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = select_result(rem_sel_q, word_q, fix_quo, fix_rem);
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                if (flush_i || resp_rdy_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            rdy_en_q  <= 1'b0;
            rem_sel_q <= 1'b0;
            word_q    <= 1'b0;
            tag_q     <= '0;
            fix_q     <= 1'b0;
            kill_q    <= 1'b0;
            a0_q      <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            res_q     <= '0;
            div_op1_q <= '0;
            div_op2_q <= '0;
        end else begin
            state_q   <= state_d;
            rdy_en_q  <= 1'b1;
            rem_sel_q <= rem_sel_d;
            word_q    <= word_d;
            tag_q     <= tag_d;
            fix_q     <= fix_d;
            kill_q    <= kill_d;
            a0_q      <= a0_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            res_q     <= res_d;
            div_op1_q <= div_op1_d;
            div_op2_q <= div_op2_d;
        end
    end

endmodule

// File: tb/tb_rv_div_ctrl.sv
// Testbench for rv_div_ctrl.
// Contains a behavioural model of the signed 64-bit divider core, a table of
// operations with their expected results, and a scoreboard queue that pairs
// each accepted request with its response. Also contains hand-written
// sequences for flush and response back-pressure.
module tb_rv_div_ctrl;

    localparam int XLEN     = 64;
    localparam int TAG_W    = 5;
    localparam int CORE_LAT = 6;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    logic             clk;
    logic             rstn;
    logic             req_vld_i;
    logic             req_rdy_o;
    logic [2:0]       funct3_i;
    logic             word_i;
    logic [XLEN-1:0]  op1_i;
    logic [XLEN-1:0]  op2_i;
    logic [TAG_W-1:0] tag_i;
    logic             flush_i;
    logic             resp_vld_o;
    logic             resp_rdy_i;
    logic [XLEN-1:0]  resp_data_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic             busy_o;
    logic             div_vld_o;
    logic [XLEN-1:0]  div_op1_o;
    logic [XLEN-1:0]  div_op2_o;
    logic [XLEN-1:0]  div_quo_i;
    logic [XLEN-1:0]  div_rem_i;
    logic             div_ready_i;

    rv_div_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_vld_i   (req_vld_i),
        .req_rdy_o   (req_rdy_o),
        .funct3_i    (funct3_i),
        .word_i      (word_i),
        .op1_i       (op1_i),
        .op2_i       (op2_i),
        .tag_i       (tag_i),
        .flush_i     (flush_i),
        .resp_vld_o  (resp_vld_o),
        .resp_rdy_i  (resp_rdy_i),
        .resp_data_o (resp_data_o),
        .resp_tag_o  (resp_tag_o),
        .busy_o      (busy_o),
        .div_vld_o   (div_vld_o),
        .div_op1_o   (div_op1_o),
        .div_op2_o   (div_op2_o),
        .div_quo_i   (div_quo_i),
        .div_rem_i   (div_rem_i),
        .div_ready_i (div_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural divider core: samples on vld&ready, drops ready while it
    // works, then raises ready with truncating signed results.
    logic            coreRdy;
    logic [XLEN-1:0] coreA, coreB, coreQ, coreR;
    int              coreCnt;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coreRdy <= 1'b1;
            coreCnt <= 0;
            coreA   <= '0;
            coreB   <= '0;
            coreQ   <= '0;
            coreR   <= '0;
        end else if (coreRdy && div_vld_o) begin
            coreRdy <= 1'b0;
            coreA   <= div_op1_o;
            coreB   <= div_op2_o;
            coreCnt <= CORE_LAT;
        end else if (!coreRdy) begin
            if (coreCnt == 0) begin
                coreRdy <= 1'b1;
                if (coreB == '0) begin
                    coreQ <= '1;
                    coreR <= coreA;
                end else if (coreB == '1) begin
                    coreQ <= -coreA;
                    coreR <= '0;
                end else begin
                    coreQ <= $signed(coreA) / $signed(coreB);
                    coreR <= $signed(coreA) % $signed(coreB);
                end
            end else begin
                coreCnt <= coreCnt - 1;
            end
        end
    end

    assign div_ready_i = coreRdy;
    assign div_quo_i   = coreQ;
    assign div_rem_i   = coreR;

    // Counts core handshakes and records the dividend the core saw.
    int              hsCount;
    logic [XLEN-1:0] lastCoreOp1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hsCount     <= 0;
            lastCoreOp1 <= '0;
        end else if (div_vld_o && coreRdy) begin
            hsCount     <= hsCount + 1;
            lastCoreOp1 <= div_op1_o;
        end
    end

    // Scoreboard of expected responses.
    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
    } exp_t;
    exp_t sb[$];

    // Vector table.
    typedef struct {
        logic [2:0]      f3;
        logic            w;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp;
        logic            fast;
        logic            chkCop;
        logic [XLEN-1:0] cop1;
    } vec_t;
    vec_t vecs[$];

    int compared;
    int mismatched;

    function automatic void addVec(input logic [2:0] f3, input logic w,
                                   input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [XLEN-1:0] e, input logic fast,
                                   input logic chk, input logic [XLEN-1:0] cop);
        vec_t v;
        v.f3 = f3; v.w = w; v.a = a; v.b = b; v.exp = e;
        v.fast = fast; v.chkCop = chk; v.cop1 = cop;
        vecs.push_back(v);
    endfunction

    task automatic compare(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: bound expired", name);
    endtask

    // Pops the scoreboard against the response currently valid, then
    // completes the handshake.
    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            failNow("scoreboard_empty");
        end else begin
            e = sb.pop_front();
            compare("resp_data", resp_data_o, e.data);
            compare("resp_tag", 64'(resp_tag_o), 64'(e.tag));
        end
        resp_rdy_i = 1'b1;
        @(posedge clk);
        #1 resp_rdy_i = 1'b0;
    endtask

    // Waits at negedges for req_rdy_o, up to a bound.
    task automatic waitReady(output bit ok);
        int n;
        n = 0;
        while (!req_rdy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = req_rdy_o;
    endtask

    task automatic waitResp(output bit ok);
        int n;
        n = 0;
        while (!resp_vld_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = resp_vld_o;
    endtask

    task automatic applyStimulus(input vec_t v, input logic [TAG_W-1:0] tag);
        int   hs0;
        bit   ok;
        exp_t e;
        @(negedge clk);
        req_vld_i = 1'b1; funct3_i = v.f3; word_i = v.w;
        op1_i = v.a; op2_i = v.b; tag_i = tag;
        waitReady(ok);
        if (!ok) begin
            failNow("accept_timeout");
            req_vld_i = 1'b0;
            return;
        end
        hs0 = hsCount;
        @(posedge clk);
        e.data = v.exp; e.tag = tag;
        sb.push_back(e);
        #1 req_vld_i = 1'b0;
        @(negedge clk);
        compare("fast_latency", 64'(resp_vld_o), 64'(v.fast));
        waitResp(ok);
        if (!ok) begin
            failNow("resp_timeout");
            void'(sb.pop_back());
            return;
        end
        checkOutput();
        compare("core_issues", 64'(hsCount - hs0), v.fast ? 64'd0 : 64'd1);
        if (v.chkCop) begin
            compare("core_op1", lastCoreOp1, v.cop1);
        end
    endtask

    // Flush while the core is working. The result is dropped, busy stays
    // high until the core returns, and then the controller is ready again.
    task automatic flushInWait(input bit coincident);
        int n;
        bit ok, sawResp, badBusy;
        sawResp = 1'b0; badBusy = 1'b0;
        @(negedge clk);
        req_vld_i = 1'b1; funct3_i = F_DIV; word_i = 1'b0;
        op1_i = -64'sd100; op2_i = 64'd7; tag_i = 5'h11;
        waitReady(ok);
        if (!ok) begin
            failNow("kill_accept_timeout");
            req_vld_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_vld_i = 1'b0;
        @(negedge clk);
        n = 0;
        while (div_ready_i && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (!coincident) begin
            flush_i = 1'b1;
            @(negedge clk);
            flush_i = 1'b0;
        end
        n = 0;
        while (!div_ready_i && n < 50) begin
            if (!busy_o) badBusy = 1'b1;
            if (resp_vld_o) sawResp = 1'b1;
            @(negedge clk);
            n++;
        end
        if (!div_ready_i) failNow("kill_core_timeout");
        compare("kill_busy_at_done", 64'(busy_o), 64'd1);
        if (coincident) flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        compare("kill_no_resp_vld", 64'(resp_vld_o), 64'd0);
        compare("kill_req_rdy", 64'(req_rdy_o), 64'd1);
        compare("kill_busy_held", 64'(badBusy), 64'd0);
        compare("kill_no_resp_seen", 64'(sawResp), 64'd0);
    endtask

    // Response held under back-pressure for five cycles.
    task automatic holdResp();
        bit   ok;
        exp_t e;
        @(negedge clk);
        req_vld_i = 1'b1; funct3_i = F_DIVU; word_i = 1'b0;
        op1_i = 64'd5; op2_i = 64'd0; tag_i = 5'h1A;
        waitReady(ok);
        if (!ok) begin
            failNow("hold_accept_timeout");
            req_vld_i = 1'b0;
            return;
        end
        @(posedge clk);
        e.data = 64'hFFFF_FFFF_FFFF_FFFF; e.tag = 5'h1A;
        sb.push_back(e);
        #1 req_vld_i = 1'b0;
        @(negedge clk);
        waitResp(ok);
        if (!ok) begin
            failNow("hold_resp_timeout");
            void'(sb.pop_back());
            return;
        end
        for (int k = 0; k < 5; k++) begin
            compare("hold_vld", 64'(resp_vld_o), 64'd1);
            compare("hold_data", resp_data_o, 64'hFFFF_FFFF_FFFF_FFFF);
            compare("hold_tag", 64'(resp_tag_o), 64'h1A);
            @(negedge clk);
        end
        checkOutput();
    endtask

    // Flush together with resp_rdy in RESP. The response is dropped and
    // the controller returns to idle.
    task automatic flushResp();
        bit ok;
        @(negedge clk);
        req_vld_i = 1'b1; funct3_i = F_REMU; word_i = 1'b0;
        op1_i = 64'd9; op2_i = 64'd0; tag_i = 5'h05;
        waitReady(ok);
        if (!ok) begin
            failNow("fresp_accept_timeout");
            req_vld_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1 req_vld_i = 1'b0;
        @(negedge clk);
        waitResp(ok);
        if (!ok) begin
            failNow("fresp_resp_timeout");
            return;
        end
        compare("fresp_data", resp_data_o, 64'd9);
        flush_i = 1'b1; resp_rdy_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; resp_rdy_i = 1'b0;
        #1;
        compare("fresp_vld_dropped", 64'(resp_vld_o), 64'd0);
        compare("fresp_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        compared = 0; mismatched = 0;
        req_vld_i = 1'b0; funct3_i = 3'b000; word_i = 1'b0;
        op1_i = '0; op2_i = '0; tag_i = '0;
        flush_i = 1'b0; resp_rdy_i = 1'b0;
        rstn = 1'b1;
        #1 rstn = 1'b0;
        #2;
        compare("rst_req_rdy", 64'(req_rdy_o), 64'd0);
        compare("rst_resp_vld", 64'(resp_vld_o), 64'd0);
        compare("rst_busy", 64'(busy_o), 64'd0);
        compare("rst_div_vld", 64'(div_vld_o), 64'd0);
        compare("rst_resp_data", resp_data_o, 64'd0);
        compare("rst_resp_tag", 64'(resp_tag_o), 64'd0);
        compare("rst_div_op1", div_op1_o, 64'd0);
        compare("rst_div_op2", div_op2_o, 64'd0);
        #9 rstn = 1'b1;

        //     f3      w     op1                       op2                       expected                  fast  chk  core op1
        addVec(F_DIV,  1'b0, -64'sd100,                64'd7,                    64'hFFFF_FFFF_FFFF_FFF2,  1'b0, 1'b0, '0);
        addVec(F_REM,  1'b0, -64'sd100,                64'd7,                    64'hFFFF_FFFF_FFFF_FFFE,  1'b0, 1'b0, '0);
        addVec(F_DIV,  1'b0, 64'd100,                  -64'sd7,                  64'hFFFF_FFFF_FFFF_FFF2,  1'b0, 1'b0, '0);
        addVec(F_REM,  1'b0, 64'd100,                  -64'sd7,                  64'd2,                    1'b0, 1'b0, '0);
        addVec(F_DIVU, 1'b0, 64'd5,                    64'd0,                    64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 1'b0, '0);
        addVec(F_REMU, 1'b0, 64'd5,                    64'd0,                    64'd5,                    1'b1, 1'b0, '0);
        addVec(F_DIV,  1'b0, -64'sd7,                  64'd0,                    64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 1'b0, '0);
        addVec(F_REM,  1'b0, -64'sd7,                  64'd0,                    64'hFFFF_FFFF_FFFF_FFF9,  1'b1, 1'b0, '0);
        addVec(F_DIV,  1'b0, 64'h8000_0000_0000_0000,  64'hFFFF_FFFF_FFFF_FFFF,  64'h8000_0000_0000_0000,  1'b1, 1'b0, '0);
        addVec(F_REM,  1'b0, 64'h8000_0000_0000_0000,  64'hFFFF_FFFF_FFFF_FFFF,  64'd0,                    1'b1, 1'b0, '0);
        addVec(F_DIV,  1'b1, 64'h0000_0000_8000_0000,  64'hFFFF_FFFF_FFFF_FFFF,  64'hFFFF_FFFF_8000_0000,  1'b1, 1'b0, '0);
        addVec(F_DIV,  1'b1, 64'h0000_0000_8000_0000,  64'h0000_0000_FFFF_FFFF,  64'hFFFF_FFFF_8000_0000,  1'b1, 1'b0, '0);
        addVec(F_REM,  1'b1, 64'h0000_0000_8000_0000,  64'h0000_0000_FFFF_FFFF,  64'd0,                    1'b1, 1'b0, '0);
        addVec(F_DIV,  1'b1, 64'h0000_0001_2345_6789,  64'hFFFF_FFFF_0000_0000,  64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 1'b0, '0);
        addVec(F_REM,  1'b1, 64'h0000_0001_2345_6789,  64'hFFFF_FFFF_0000_0000,  64'h0000_0000_2345_6789,  1'b1, 1'b0, '0);
        addVec(F_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,  64'd3,                    64'h5555_5555_5555_5555,  1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF);
        addVec(F_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,  64'd3,                    64'd0,                    1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF);
        addVec(F_DIVU, 1'b0, 64'h8000_0000_0000_0005,  64'd10,                   64'h0CCC_CCCC_CCCC_CCCD,  1'b0, 1'b1, 64'h4000_0000_0000_0002);
        addVec(F_REMU, 1'b0, 64'h8000_0000_0000_0005,  64'd10,                   64'd3,                    1'b0, 1'b0, '0);
        addVec(F_DIVU, 1'b0, 64'h8000_0000_0000_0000,  64'd3,                    64'h2AAA_AAAA_AAAA_AAAA,  1'b0, 1'b1, 64'h4000_0000_0000_0000);
        addVec(F_REMU, 1'b0, 64'h8000_0000_0000_0000,  64'd3,                    64'd2,                    1'b0, 1'b0, '0);
        addVec(F_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,  64'h8000_0000_0000_0000,  64'd1,                    1'b1, 1'b0, '0);
        addVec(F_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF,  64'h8000_0000_0000_0000,  64'h7FFF_FFFF_FFFF_FFFF,  1'b1, 1'b0, '0);
        addVec(F_DIVU, 1'b0, 64'd5,                    64'h8000_0000_0000_0000,  64'd0,                    1'b1, 1'b0, '0);
        addVec(F_REMU, 1'b0, 64'd5,                    64'h8000_0000_0000_0000,  64'd5,                    1'b1, 1'b0, '0);
        addVec(F_DIV,  1'b1, 64'h0000_0000_FFFF_FFF9,  64'd2,                    64'hFFFF_FFFF_FFFF_FFFD,  1'b0, 1'b0, '0);
        addVec(F_REM,  1'b1, 64'h0000_0000_FFFF_FFF9,  64'd2,                    64'hFFFF_FFFF_FFFF_FFFF,  1'b0, 1'b0, '0);
        addVec(F_DIVU, 1'b1, 64'h0000_0000_FFFF_FFF9,  64'd2,                    64'h0000_0000_7FFF_FFFC,  1'b0, 1'b0, '0);
        addVec(F_REMU, 1'b1, 64'h0000_0000_FFFF_FFF9,  64'd2,                    64'd1,                    1'b0, 1'b0, '0);
        addVec(F_DIV,  1'b1, 64'hDEAD_0000_0000_0064,  64'h1234_5678_FFFF_FFF9,  64'hFFFF_FFFF_FFFF_FFF2,  1'b0, 1'b0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], 5'(i));
        end

        // A flush in idle blocks acceptance.
        @(negedge clk);
        req_vld_i = 1'b1; flush_i = 1'b1; funct3_i = F_DIV; word_i = 1'b0;
        op1_i = 64'd10; op2_i = 64'd3; tag_i = 5'h03;
        #1;
        compare("flush_idle_rdy", 64'(req_rdy_o), 64'd0);
        @(negedge clk);
        compare("flush_idle_busy", 64'(busy_o), 64'd0);
        req_vld_i = 1'b0; flush_i = 1'b0;

        flushInWait(1'b0);
        flushInWait(1'b1);
        holdResp();
        flushResp();

        // The controller must still work normally after the flushes.
        applyStimulus(vecs[0], 5'h1F);

        if (sb.size() != 0) begin
            failNow("scoreboard_leftover");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rv_div_ctrl.md
Name: rv_div_ctrl

Overview:
- Sequencer between the EX stage and the radix-4 SRT divider core for RV64M DIV/DIVU/REM/REMU and the W variants.
- Decodes the operation and prepares operands for the signed 64-bit core. The core expects a one-cycle `vld&ready` sample, and `ready` drops while busy.
- Short-circuits divide-by-zero, signed overflow and unsigned cases whose divisor MSB is set.
- Corrects unsigned dividends with MSB set, then returns a single result through a valid/ready response port.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TAG_W, 5, width of the destination tag passed through with the result.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_vld_i  in  1  request valid
- req_rdy_o  out  1  request ready
- funct3_i  in  3  100=DIV, 101=DIVU, 110=REM, 111=REMU
- word_i  in  1  1 = *W variant
- op1_i  in  XLEN  dividend rs1
- op2_i  in  XLEN  divisor rs2
- tag_i  in  TAG_W  destination tag
- flush_i  in  1  pipeline kill
- resp_vld_o  out  1  result valid
- resp_rdy_i  in  1  result accepted
- resp_data_o  out  XLEN  result
- resp_tag_o  out  TAG_W  tag
- busy_o  out  1  state is not IDLE
- div_vld_o  out  1  to core vld_i
- div_op1_o  out  XLEN  to core op1_i
- div_op2_o  out  XLEN  to core op2_i
- div_quo_i  in  XLEN  core quotient
- div_rem_i  in  XLEN  core remainder
- div_ready_i  in  1  core ready_o

Behaviour:
- Reset values: `req_rdy_o`, `resp_vld_o`, `busy_o` and `div_vld_o` are 0. `resp_data_o`, `resp_tag_o`, `div_op1_o` and `div_op2_o` are 0. State is IDLE. Reset mid-operation abandons the operation with no response; the core is reset by the same `rstn`.
- States: IDLE, ISSUE, BUSY, WAIT, FIX, RESP. `req_rdy_o` = (state==IDLE) and not `flush_i`. A request is accepted on `req_vld_i & req_rdy_o`, which registers funct3, word, op1, op2 and tag.
- Operand prep, signed (funct3[0]=0):
  - Word: sign-extend bits [31:0].
  - 64-bit: operands pass unchanged.
- Operand prep, unsigned (funct3[0]=1):
  - Word: zero-extend bits [31:0].
  - 64-bit: A = op1 and B = op2 pass unchanged unless an MSB-set case below applies.
- Fast path, IDLE -> RESP, resp_vld one cycle after acceptance:
  - B==0: quotient = all ones, remainder = A.
  - Signed, A = most negative value and B = -1 (64-bit or word): quotient = A, remainder = 0.
  - Unsigned 64-bit with B[63]=1: quotient = (A>=B unsigned), remainder = A - quotient·B.
- Unsigned 64-bit with A[63]=1 and B[63]=0:
  - Send A>>1 and B to the core; set the fix flag.
- Core path:
  - ISSUE: drive `div_vld_o`=1 with the prepared operands until `div_vld_o & div_ready_i`, then go to BUSY.
  - BUSY: wait for `div_ready_i`=0, then go to WAIT.
  - WAIT: on `div_ready_i`=1, capture `div_quo_i` (q') and `div_rem_i` (r'); go to FIX if the fix flag is set, else to RESP.
- FIX, one cycle, 65-bit arithmetic:
  - r = 2r' + A[0].
  - If r >= B: quotient = 2q'+1 and remainder = r-B.
  - Otherwise: quotient = 2q' and remainder = r.
- Result select: funct3[1]=0 selects the quotient, 1 selects the remainder. Word variants sign-extend bit 31 of the selected value.
- RESP: hold `resp_vld_o`, `resp_data_o` and `resp_tag_o` stable until `resp_rdy_i`, then go to IDLE. A new request is accepted the cycle after IDLE is re-entered; there is no back-to-back accept in the same cycle.
- flush_i:
  - In IDLE: blocks acceptance.
  - In ISSUE before acceptance: go to IDLE immediately with `div_vld_o` low.
  - In BUSY, WAIT or FIX: set a kill flag and continue until the core returns, then go to IDLE without asserting `resp_vld_o`.
  - In RESP: drop `resp_vld_o` next cycle and go to IDLE.
  - A flush coincident with `resp_rdy_i` is treated as a flush.
- A flush coincident with core completion in WAIT still discards the result.
- `busy_o` = state != IDLE.

Test Plan:
- DIV: op1 = -100, op2 = 7 -> core issued once; resp 0xFFFFFFFFFFFFFFF2 (-14). Same operands with REM -> 0xFFFFFFFFFFFFFFFE (-2).
- DIVU, op2 = 0, op1 = 5 -> resp_vld at T+1, data 0xFFFFFFFFFFFFFFFF, div_vld_o never asserted. REMU with the same operands -> 5.
- DIV, op1 = 0x8000000000000000, op2 = -1 -> 0x8000000000000000 at T+1. REM -> 0. DIVW with op1 = 0x80000000, op2 = -1 -> 0xFFFFFFFF80000000.
- DIVU, op1 = 0xFFFFFFFFFFFFFFFF, op2 = 3 -> core sees op1 = 0x7FFFFFFFFFFFFFFF; after FIX resp 0x5555555555555555; REMU -> 0. DIVU with op2 = 0x8000000000000000 -> 1; REMU -> 0x7FFFFFFFFFFFFFFF, fast path.
- DIVW, op1 = 0x00000000FFFFFFF9, op2 = 2 -> 0xFFFFFFFFFFFFFFFD. REMW -> 0xFFFFFFFFFFFFFFFF. DIVUW with the same operands -> 0x000000007FFFFFFC.
- flush_i pulsed in WAIT -> no resp_vld; busy_o stays high until div_ready_i rises, then req_rdy_o is 1 next cycle. resp_rdy_i held low for 5 cycles in RESP -> data and tag stable throughout.
